pipe_hazard_ctrl: RTL and testbench

Hazard controller that drives the enable and clear controls of the pipeline stage registers. It detects load-use data hazards and taken branches/jumps, and sequences multi-cycle stalls and flushes through a small FSM. It sits in the ID stage, beside the IF/ID and ID/EX stage registers and the PC register, and drives their enable inputs.

---
 rtl/pipe_hazard_ctrl.sv | 130 +++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls and branch/jump flushes sequenced by a small FSM.
// Optional event counters are enabled by defining PIPE_HAZARD_STATS_EN.
module pipe_hazard_ctrl #(
  parameter int unsigned REG_ADDR_W   = 5,
  parameter int unsigned STALL_CYCLES = 1,
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  idex_mem_read,
  input  logic [REG_ADDR_W-1:0] idex_rt,
  input  logic                  branch_taken,
  input  logic                  jump,
  output logic                  pc_enable,
  output logic                  ifid_enable,
  output logic                  ifid_flush,
  output logic                  idex_bubble,
  output logic                  busy
`ifdef PIPE_HAZARD_STATS_EN
  ,
  output logic [15:0]           stall_events,
  output logic [15:0]           flush_events
`endif
);

  typedef enum logic [1:0] {StRun, StStall, StFlush} state_e;

  localparam logic [3:0] StallInit  = 4'(STALL_CYCLES - 1);
  localparam logic [3:0] FlushInit  = 4'(FLUSH_CYCLES - 1);
  localparam bit         MultiStall = (STALL_CYCLES > 1);
  localparam bit         MultiFlush = (FLUSH_CYCLES > 1);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       hazard, redirect;
  logic       pc_en, ifid_en, flush, bubble;

  // $0 is hardwired to zero, so a load targeting it cannot create a dependency.
  assign hazard = idex_mem_read && (idex_rt != '0) &&
                  ((idex_rt == id_rs) || (idex_rt == id_rt));
  assign redirect = branch_taken || jump;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pc_en   = 1'b1;
    ifid_en = 1'b1;
    flush   = 1'b0;
    bubble  = 1'b0;
    unique case (state_q)
      StRun, StStall: begin
        if (redirect) begin
          flush  = 1'b1;
          bubble = 1'b1;
          if (MultiFlush) begin
            state_d = StFlush;
            cnt_d   = FlushInit;
          end else begin
            state_d = StRun;
            cnt_d   = 4'd0;
          end
        end else if (state_q == StStall) begin
          pc_en   = 1'b0;
          ifid_en = 1'b0;
          bubble  = 1'b1;
          if (cnt_q <= 4'd1) begin
            state_d = StRun;
            cnt_d   = 4'd0;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end else if (hazard) begin
          pc_en   = 1'b0;
          ifid_en = 1'b0;
          bubble  = 1'b1;
          if (MultiStall) begin
            state_d = StStall;
            cnt_d   = StallInit;
          end
        end
      end
      StFlush: begin
        // ID holds a flushed NOP here, so hazards are not considered.
        flush  = 1'b1;
        bubble = 1'b1;
        if (cnt_q <= 4'd1) begin
          state_d = StRun;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = StRun;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StRun;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pc_enable   = reset & pc_en;
  assign ifid_enable = reset & ifid_en;
  assign ifid_flush  = reset & flush;
  assign idex_bubble = reset & bubble;
  assign busy        = reset & (state_q != StRun);

`ifdef PIPE_HAZARD_STATS_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_events <= 16'd0;
      flush_events <= 16'd0;
    end else begin
      if ((state_q == StRun) && hazard && !redirect) stall_events <= stall_events + 16'd1;
      if (redirect) flush_events <= flush_events + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: instance a (1 stall, 1 flush) and b (3 stalls, 2 flushes).
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] id_rs, id_rt, idex_rt;
  logic       idex_mem_read, branch_taken, jump;

  logic a_pc, a_ifid, a_flush, a_bub, a_busy;
  logic b_pc, b_ifid, b_flush, b_bub, b_busy;
`ifdef PIPE_HAZARD_STATS_EN
  logic [15:0] a_stall_ev, a_flush_ev, b_stall_ev, b_flush_ev;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.REG_ADDR_W(5), .STALL_CYCLES(1), .FLUSH_CYCLES(1)) dut_a (
    .clk           (clk),
    .reset         (reset),
    .id_rs         (id_rs),
    .id_rt         (id_rt),
    .idex_mem_read (idex_mem_read),
    .idex_rt       (idex_rt),
    .branch_taken  (branch_taken),
    .jump          (jump),
    .pc_enable     (a_pc),
    .ifid_enable   (a_ifid),
    .ifid_flush    (a_flush),
    .idex_bubble   (a_bub),
    .busy          (a_busy)
`ifdef PIPE_HAZARD_STATS_EN
    ,
    .stall_events  (a_stall_ev),
    .flush_events  (a_flush_ev)
`endif
  );

  pipe_hazard_ctrl #(.REG_ADDR_W(5), .STALL_CYCLES(3), .FLUSH_CYCLES(2)) dut_b (
    .clk           (clk),
    .reset         (reset),
    .id_rs         (id_rs),
    .id_rt         (id_rt),
    .idex_mem_read (idex_mem_read),
    .idex_rt       (idex_rt),
    .branch_taken  (branch_taken),
    .jump          (jump),
    .pc_enable     (b_pc),
    .ifid_enable   (b_ifid),
    .ifid_flush    (b_flush),
    .idex_bubble   (b_bub),
    .busy          (b_busy)
`ifdef PIPE_HAZARD_STATS_EN
    ,
    .stall_events  (b_stall_ev),
    .flush_events  (b_flush_ev)
`endif
  );

  // Output vectors: {pc_enable, ifid_enable, ifid_flush, idex_bubble, busy}
  logic [4:0] va, vb;
  assign va = {a_pc, a_ifid, a_flush, a_bub, a_busy};
  assign vb = {b_pc, b_ifid, b_flush, b_bub, b_busy};

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_rs         = 5'd0;
    id_rt         = 5'd0;
    idex_rt       = 5'd0;
    idex_mem_read = 1'b0;
    branch_taken  = 1'b0;
    jump          = 1'b0;
  endtask

  task automatic load_use(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] ld);
    id_rs         = rs;
    id_rt         = rt;
    idex_rt       = ld;
    idex_mem_read = 1'b1;
  endtask

  initial begin
    // Reset held for three cycles; outputs gated low even with a redirect present.
    reset = 1'b0;
    idle();
    tick(); tick(); tick();
    chk("rst_a", 16'(va), 16'b00000);
    chk("rst_b", 16'(vb), 16'b00000);
    branch_taken = 1'b1;
    #1;
    chk("rst_gate_b", 16'(vb), 16'b00000);
    idle();

    reset = 1'b1;
    #1;
    chk("post_rst_a", 16'(va), 16'b11000);
    chk("post_rst_b", 16'(vb), 16'b11000);
    tick();

    // Load-use through rs
    load_use(5'd8, 5'd0, 5'd8);
    #1;
    chk("hz_c0_a", 16'(va), 16'b00010);
    chk("hz_c0_b", 16'(vb), 16'b00010);
    tick();
    idle();
    #1;
    chk("hz_c1_a", 16'(va), 16'b11000);
    chk("hz_c1_b", 16'(vb), 16'b00011);
    tick();
    chk("hz_c2_b", 16'(vb), 16'b00011);
    tick();
    chk("hz_c3_b", 16'(vb), 16'b11000);

    // No hazard for $0 target or for a non-load
    load_use(5'd0, 5'd0, 5'd0);
    #1;
    chk("r0_a", 16'(va), 16'b11000);
    chk("r0_b", 16'(vb), 16'b11000);
    load_use(5'd5, 5'd0, 5'd5);
    idex_mem_read = 1'b0;
    #1;
    chk("noload_b", 16'(vb), 16'b11000);
    load_use(5'd9, 5'd0, 5'd0);
    #1;
    chk("r0_rt_b", 16'(vb), 16'b11000);
    tick();
    idle();

    // Branch pulse; hazard during the second flush cycle is ignored by b
    branch_taken = 1'b1;
    #1;
    chk("br_c0_a", 16'(va), 16'b11110);
    chk("br_c0_b", 16'(vb), 16'b11110);
    tick();
    idle();
    load_use(5'd0, 5'd9, 5'd9);
    #1;
    chk("br_c1_a", 16'(va), 16'b00010);
    chk("br_c1_b", 16'(vb), 16'b11111);
    tick();
    idle();
    #1;
    chk("br_c2_a", 16'(va), 16'b11000);
    chk("br_c2_b", 16'(vb), 16'b11000);

    // Jump on the second stall cycle of b aborts the stall
    load_use(5'd0, 5'd9, 5'd9);
    #1;
    chk("js_c0_b", 16'(vb), 16'b00010);
    tick();
    idle();
    jump = 1'b1;
    #1;
    chk("js_c1_a", 16'(va), 16'b11110);
    chk("js_c1_b", 16'(vb), 16'b11111);
    tick();
    idle();
    #1;
    chk("js_c2_a", 16'(va), 16'b11000);
    chk("js_c2_b", 16'(vb), 16'b11111);
    tick();
    chk("js_c3_b", 16'(vb), 16'b11000);

    // Reset on the second stall cycle abandons the stall
    load_use(5'd0, 5'd9, 5'd9);
    #1;
    chk("rs_c0_b", 16'(vb), 16'b00010);
    tick();
    idle();
    reset = 1'b0;
    #1;
    chk("rs_c1_a", 16'(va), 16'b00000);
    chk("rs_c1_b", 16'(vb), 16'b00000);
    tick();
    reset = 1'b1;
    #1;
    chk("rs_c2_b", 16'(vb), 16'b11000);
`ifdef PIPE_HAZARD_STATS_EN
    chk("stall_ev_rst_b", b_stall_ev, 16'd0);
    chk("flush_ev_rst_b", b_flush_ev, 16'd0);
`endif
    tick();
    chk("rs_c3_b", 16'(vb), 16'b11000);

    load_use(5'd4, 5'd0, 5'd4);
    #1;
    chk("rs_hz_b", 16'(vb), 16'b00010);
    tick();
    idle();
`ifdef PIPE_HAZARD_STATS_EN
    chk("stall_ev_1_a", a_stall_ev, 16'd1);
    chk("stall_ev_1_b", b_stall_ev, 16'd1);
`endif
    tick();
    tick();
    chk("rs_end_b", 16'(vb), 16'b11000);

    // branch_taken and jump together form a single redirect
    branch_taken = 1'b1;
    jump         = 1'b1;
    #1;
    chk("bj_a", 16'(va), 16'b11110);
    chk("bj_b", 16'(vb), 16'b11110);
    tick();
    idle();
    #1;
`ifdef PIPE_HAZARD_STATS_EN
    chk("flush_ev_1_a", a_flush_ev, 16'd1);
    chk("flush_ev_1_b", b_flush_ev, 16'd1);
`endif
    chk("bj_c1_b", 16'(vb), 16'b11111);
    tick();
    chk("bj_c2_b", 16'(vb), 16'b11000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
